// File: rtl/fmdll_pkg.sv
// Shared types and constants for the FMDLL divide-by-M sequencer.
package fmdll_pkg;

    localparam int FMDLL_MW  = 2;
    localparam int FMDLL_DCW = 6;

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_TRACK  = 1'b1
    } fmdll_state_e;

    // Delay-line midpoint: the code the loop starts from after reset.
    function automatic int unsigned dl_code_mid(input int unsigned dcw);
        return 32'd1 << (dcw - 1);
    endfunction

endpackage

// File: rtl/fmdll_mult_ctrl_if.sv
// Ratio-change request channel between a requester and the FMDLL sequencer.
interface fmdll_mult_ctrl_if
    import fmdll_pkg::*;
#(
    parameter int MW = FMDLL_MW
);
    logic [MW-1:0] m_req;
    logic          m_req_vld;
    logic          m_req_rdy;

    modport master (output m_req, output m_req_vld, input m_req_rdy);
    modport slave  (input m_req, input m_req_vld, output m_req_rdy);

endinterface

// File: rtl/fmdll_wrap_cnt.sv
// Divide-by-M phase counter: counts 0..M-1 and flags the last phase.
module fmdll_wrap_cnt
    import fmdll_pkg::*;
#(
    parameter int MW = FMDLL_MW
) (
    input  logic          clk_ext,
    input  logic          rst_n,
    input  logic [MW-1:0] M,
    input  logic          load_zero,
    output logic [MW-1:0] M_counter,
    output logic          wrap_evt,
    output logic          wrap
);

    logic [MW-1:0] cnt_reg;
    logic [MW-1:0] cnt_next;
    logic [MW-1:0] m_last;
    logic          wrap_reg;

    always_comb begin
        m_last = M - MW'(1);
    end

    assign wrap_evt = (cnt_reg == m_last);

    always_comb begin
        cnt_next = cnt_reg + MW'(1);
        if (load_zero || wrap_evt) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            wrap_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            wrap_reg <= wrap_evt;
        end
    end

    assign M_counter = cnt_reg;
    assign wrap      = wrap_reg;

endmodule

// File: rtl/fmdll_mult_ctrl.sv
// FMDLL divide-by-M sequencer: glitch-free ratio changes at counter wraps,
// settle/track FSM stepping the delay-line code, and lock detection.
module fmdll_mult_ctrl
    import fmdll_pkg::*;
#(
    parameter int MW           = FMDLL_MW,
    parameter int DCW          = FMDLL_DCW,
    parameter int M_RST        = 1,
    parameter int SETTLE_WRAPS = 8,
    parameter int LOCK_WRAPS   = 4
) (
    input  logic               clk_ext,
    input  logic               rst_n,
    fmdll_mult_ctrl_if.slave   req_if,
    input  logic               up,
    input  logic               dn,
    output logic [MW-1:0]      M,
    output logic [MW-1:0]      M_counter,
    output logic               wrap,
    output logic [DCW-1:0]     dl_code,
    output logic               locked,
    output logic               settling
);

    localparam int SCW = (SETTLE_WRAPS > 1) ? $clog2(SETTLE_WRAPS) : 1;
    localparam int LCW = (LOCK_WRAPS > 1) ? $clog2(LOCK_WRAPS) : 1;

    localparam logic [DCW-1:0] CODE_MID    = DCW'(dl_code_mid(DCW));
    localparam logic [DCW-1:0] CODE_MAX    = '1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_WRAPS - 1);
    localparam logic [LCW-1:0] LOCK_LAST   = LCW'(LOCK_WRAPS - 1);
    localparam logic [MW-1:0]  M_RST_V     = MW'(M_RST);

    fmdll_state_e   state_reg, state_next;

    logic [MW-1:0]  m_reg, m_next;
    logic [MW-1:0]  m_pend_reg, m_pend_next;
    logic           pend_reg, pend_next;
    logic           rdy_reg, rdy_next;
    logic [DCW-1:0] code_reg, code_next;
    logic           locked_reg, locked_next;
    logic [SCW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [LCW-1:0] lock_cnt_reg, lock_cnt_next;
    logic           prev_up_reg, prev_up_next;
    logic           prev_dn_reg, prev_dn_next;

    logic           wrap_evt;
    logic           accept;
    logic           apply;
    logic           ratio_chg;
    logic [MW-1:0]  m_req_clamp;
    logic           settle_evt;
    logic           track_evt;
    logic           step_up;
    logic           step_dn;

    fmdll_wrap_cnt #(
        .MW (MW)
    ) u_wrap_cnt (
        .clk_ext   (clk_ext),
        .rst_n     (rst_n),
        .M         (m_reg),
        .load_zero (ratio_chg),
        .M_counter (M_counter),
        .wrap_evt  (wrap_evt),
        .wrap      (wrap)
    );

    // A pending ratio can only be applied on the last divider phase, so the
    // divided clock always completes its current period before M changes.
    assign accept      = req_if.m_req_vld & rdy_reg;
    assign m_req_clamp = (req_if.m_req == '0) ? MW'(1) : req_if.m_req;
    assign apply       = wrap_evt & pend_reg;
    assign ratio_chg   = apply & (m_pend_reg != m_reg);

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_SETTLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (ratio_chg) begin
            state_next = ST_SETTLE;
        end else if (wrap_evt && (state_reg == ST_SETTLE) && (settle_cnt_reg == SETTLE_LAST)) begin
            state_next = ST_TRACK;
        end
    end

    always_comb begin
        settling   = (state_reg == ST_SETTLE);
        settle_evt = wrap_evt & settling & ~ratio_chg;
        track_evt  = wrap_evt & ~settling & ~ratio_chg;
    end

    // Saturated requests are not steps, so a loop pinned at a rail can lock.
    assign step_up = track_evt & up & ~dn & (code_reg != CODE_MAX);
    assign step_dn = track_evt & dn & ~up & (code_reg != '0);

    always_comb begin
        m_next          = m_reg;
        m_pend_next     = m_pend_reg;
        pend_next       = pend_reg;
        code_next       = code_reg;
        locked_next     = locked_reg;
        settle_cnt_next = settle_cnt_reg;
        lock_cnt_next   = lock_cnt_reg;
        prev_up_next    = prev_up_reg;
        prev_dn_next    = prev_dn_reg;

        if (accept) begin
            m_pend_next = m_req_clamp;
            pend_next   = 1'b1;
        end
        if (apply) begin
            pend_next = 1'b0;
        end

        if (ratio_chg) begin
            m_next          = m_pend_reg;
            locked_next     = 1'b0;
            lock_cnt_next   = '0;
            settle_cnt_next = '0;
            prev_up_next    = 1'b0;
            prev_dn_next    = 1'b0;
        end else if (settle_evt) begin
            settle_cnt_next = (settle_cnt_reg == SETTLE_LAST) ? '0 : settle_cnt_reg + SCW'(1);
            prev_up_next    = 1'b0;
            prev_dn_next    = 1'b0;
        end else if (track_evt) begin
            if (step_up) begin
                code_next = code_reg + DCW'(1);
            end else if (step_dn) begin
                code_next = code_reg - DCW'(1);
            end
            if (step_up || step_dn) begin
                lock_cnt_next = '0;
                if (locked_reg && ((step_up && prev_up_reg) || (step_dn && prev_dn_reg))) begin
                    locked_next = 1'b0;
                end
            end else if (lock_cnt_reg == LOCK_LAST) begin
                locked_next = 1'b1;
            end else begin
                lock_cnt_next = lock_cnt_reg + LCW'(1);
            end
            prev_up_next = step_up;
            prev_dn_next = step_dn;
        end

        rdy_next = ~pend_next;
    end

    always_ff @(posedge clk_ext or negedge rst_n) begin
        if (!rst_n) begin
            m_reg          <= M_RST_V;
            m_pend_reg     <= '0;
            pend_reg       <= 1'b0;
            rdy_reg        <= 1'b0;
            code_reg       <= CODE_MID;
            locked_reg     <= 1'b0;
            settle_cnt_reg <= '0;
            lock_cnt_reg   <= '0;
            prev_up_reg    <= 1'b0;
            prev_dn_reg    <= 1'b0;
        end else begin
            m_reg          <= m_next;
            m_pend_reg     <= m_pend_next;
            pend_reg       <= pend_next;
            rdy_reg        <= rdy_next;
            code_reg       <= code_next;
            locked_reg     <= locked_next;
            settle_cnt_reg <= settle_cnt_next;
            lock_cnt_reg   <= lock_cnt_next;
            prev_up_reg    <= prev_up_next;
            prev_dn_reg    <= prev_dn_next;
        end
    end

    assign req_if.m_req_rdy = rdy_reg;
    assign M                = m_reg;
    assign dl_code          = code_reg;
    assign locked           = locked_reg;

endmodule

// File: tb/tb_fmdll_mult_ctrl.sv
// Bench for fmdll_mult_ctrl: cycle scoreboard against a behavioural model
// plus directed checks of the settle, lock, ratio-change and reset scenarios.
module tb_fmdll_mult_ctrl;
    import fmdll_pkg::*;

    localparam int MW  = 2;
    localparam int DCW = 6;

    logic           clk_ext = 1'b0;
    logic           rst_n   = 1'b0;
    logic           up      = 1'b0;
    logic           dn      = 1'b0;
    logic [MW-1:0]  M;
    logic [MW-1:0]  M_counter;
    logic           wrap;
    logic [DCW-1:0] dl_code;
    logic           locked;
    logic           settling;

    fmdll_mult_ctrl_if #(.MW(MW)) rif ();

    fmdll_mult_ctrl #(
        .MW           (MW),
        .DCW          (DCW),
        .M_RST        (1),
        .SETTLE_WRAPS (8),
        .LOCK_WRAPS   (4)
    ) dut (
        .clk_ext   (clk_ext),
        .rst_n     (rst_n),
        .req_if    (rif.slave),
        .up        (up),
        .dn        (dn),
        .M         (M),
        .M_counter (M_counter),
        .wrap      (wrap),
        .dl_code   (dl_code),
        .locked    (locked),
        .settling  (settling)
    );

    always #5 clk_ext = ~clk_ext;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Behavioural model state, advanced once per clock by the stimulus process.
    logic [1:0] md_m, md_cnt, md_mpend;
    logic       md_wrap, md_locked, md_track, md_pend, md_rdy, md_pu, md_pd;
    logic [5:0] md_code;
    int         md_scnt, md_lcnt;

    logic [13:0] sb_q[$];

    task automatic model_reset();
        md_m = 2'd1; md_cnt = 2'd0; md_mpend = 2'd0; md_wrap = 1'b0;
        md_locked = 1'b0; md_track = 1'b0; md_pend = 1'b0; md_rdy = 1'b0;
        md_pu = 1'b0; md_pd = 1'b0; md_code = 6'd32; md_scnt = 0; md_lcnt = 0;
    endtask

    task automatic model_step();
        logic [1:0] last_phase, old_mpend;
        logic       wevt, chg, su, sd;
        last_phase = md_m - 2'd1;
        wevt       = (md_cnt == last_phase);
        old_mpend  = md_mpend;
        chg        = 1'b0;
        if (wevt && md_pend) begin
            md_pend = 1'b0;
            chg     = (old_mpend != md_m);
        end else if (rif.m_req_vld && md_rdy) begin
            md_mpend = (rif.m_req == 2'd0) ? 2'd1 : rif.m_req;
            md_pend  = 1'b1;
        end
        md_wrap = wevt;
        md_cnt  = (wevt || chg) ? 2'd0 : md_cnt + 2'd1;
        if (chg) begin
            md_m = old_mpend; md_track = 1'b0; md_scnt = 0; md_lcnt = 0;
            md_locked = 1'b0; md_pu = 1'b0; md_pd = 1'b0;
        end else if (wevt && !md_track) begin
            if (md_scnt == 7) begin md_track = 1'b1; md_scnt = 0; end
            else md_scnt++;
        end else if (wevt) begin
            su = up && !dn && (md_code < 6'd63);
            sd = dn && !up && (md_code > 6'd0);
            if (su) md_code = md_code + 6'd1;
            if (sd) md_code = md_code - 6'd1;
            if (su || sd) begin
                md_lcnt = 0;
                if (md_locked && ((su && md_pu) || (sd && md_pd))) md_locked = 1'b0;
            end else if (md_lcnt == 3) md_locked = 1'b1;
            else md_lcnt++;
            md_pu = su; md_pd = sd;
        end
        md_rdy = !md_pend;
    endtask

    // Called at negedge+1 with inputs settled; the monitor compares at the next negedge.
    task automatic tick();
        if (!rst_n) model_reset();
        else        model_step();
        sb_q.push_back({md_m, md_cnt, md_wrap, md_code, md_locked, !md_track, md_rdy});
        @(negedge clk_ext);
        #1;
    endtask

    always @(negedge clk_ext) begin
        if (sb_q.size() > 0) begin
            logic [13:0] exp_snap;
            exp_snap = sb_q.pop_front();
            check("cycle", {M, M_counter, wrap, dl_code, locked, settling, rif.m_req_rdy}, exp_snap);
        end
    end

    task automatic do_req(input logic [1:0] val);
        logic ok;
        ok = 1'b0;
        rif.m_req     = val;
        rif.m_req_vld = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = rif.m_req_rdy;
            tick();
        end
        rif.m_req_vld = 1'b0;
        check("req_accept", ok, 1);
        $display("[TB] request m_req=%0d accepted=%0d M=%0d", val, ok, M);
    endtask

    initial begin
        int n, bad;
        rif.m_req     = 2'd0;
        rif.m_req_vld = 1'b0;
        @(negedge clk_ext);
        #1;
        repeat (3) tick();
        check("rst_M", M, 1);
        check("rst_code", dl_code, 32);
        check("rst_rdy", rif.m_req_rdy, 0);
        check("rst_settling", settling, 1);
        check("rst_cnt", M_counter, 0);

        // Ramp from midpoint to the top rail at M=1.
        rst_n = 1'b1;
        up    = 1'b1;
        n     = 0;
        bad   = 0;
        for (int i = 0; i < 50; i++) begin
            if (settling) n++;
            if (locked && dl_code != 6'd63) bad++;
            tick();
            if (i == 0) check("rdy_release", rif.m_req_rdy, 1);
        end
        check("t1_settle_len", n, 8);
        check("t1_lock_while_step", bad, 0);
        check("t1_code_sat", dl_code, 63);
        check("t1_locked_rail", locked, 1);
        $display("[TB] ramp: settle=%0d code=%0d locked=%0d", n, dl_code, locked);

        // Move to M=3 and measure lock latency after SETTLE exit.
        up = 1'b0;
        do_req(2'd3);
        tick();
        check("t2_settle_entry", settling, 1);
        n = 0;
        while (settling && n < 200) begin tick(); n++; end
        check("t2_settle_done", settling, 0);
        n = 0;
        while (!locked && n < 100) begin tick(); n++; end
        check("t2_lock_delay", n, 12);
        check("t2_M", M, 3);
        check("t2_code", dl_code, 63);
        $display("[TB] track M=3: lock after %0d cycles", n);

        // Same ratio again: no resettle, lock kept.
        do_req(2'd3);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (settling || !locked) bad++;
        end
        check("t4_lock_kept", bad, 0);
        check("t4_rdy_back", rif.m_req_rdy, 1);

        // Mid-period change to M=2.
        n = 0;
        while (M_counter != 2'd1 && n < 10) begin tick(); n++; end
        do_req(2'd2);
        check("t3_rdy_drop", rif.m_req_rdy, 0);
        check("t3_M_hold", M, 3);
        check("t3_cnt_last", M_counter, 2);
        tick();
        check("t3_M_new", M, 2);
        check("t3_cnt_zero", M_counter, 0);
        check("t3_unlock", locked, 0);
        n = 0;
        while (settling && n < 100) begin n++; tick(); end
        check("t3_settle_len", n, 16);
        check("t3_code_kept", dl_code, 63);
        $display("[TB] change to M=2: settle=%0d cycles", n);

        // Zero request clamps to M=1.
        do_req(2'd0);
        n = 0;
        while (M != 2'd1 && n < 10) begin tick(); n++; end
        check("t5_M_clamp", M, 1);
        tick();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (!wrap || M_counter != 2'd0) bad++;
            tick();
        end
        check("t5_wrap_every", bad, 0);

        // Reset with a request pending in SETTLE.
        check("t6_pre_rdy", rif.m_req_rdy, 1);
        rif.m_req     = 2'd2;
        rif.m_req_vld = 1'b1;
        tick();
        rif.m_req_vld = 1'b0;
        check("t6_pending", rif.m_req_rdy, 0);
        rst_n = 1'b0;
        #1;
        check("t6_async", {M, M_counter, wrap, dl_code, locked, settling, rif.m_req_rdy},
              {2'd1, 2'd0, 1'b0, 6'd32, 1'b0, 1'b1, 1'b0});
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (M != 2'd1) bad++;
        end
        check("t6_req_lost", bad, 0);
        $display("[TB] reset with pending request: M=%0d", M);

        @(negedge clk_ext);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fmdll_mult_ctrl.md
Name: fmdll_mult_ctrl

Overview:
Sequencer for the FMDLL divide-by-M path.
- Owns the M_counter that drives the divide-by-M flop, and the applied ratio M.
- Accepts ratio-change requests over a valid/ready handshake and applies them only at a counter wrap, so the divided clock never glitches.
- Runs a settle/track FSM that steps the delay-line control code from phase-detector up/dn and reports lock.

Parameters:
MW, 2, width of M and M_counter
DCW, 6, width of delay-line control code
M_RST, 1, ratio applied out of reset (1..2^MW-1)
SETTLE_WRAPS, 8, counter wraps to wait after reset or ratio change before tracking
LOCK_WRAPS, 4, consecutive no-step wraps required to assert locked

Ports:
clk_ext  in   1    reference clock; all state on rising edge
rst_n    in   1    asynchronous active-low reset
m_req    in   MW   requested ratio
m_req_vld in  1    request valid
m_req_rdy out 1    controller can accept a request
up       in   1    phase detector: feedback early
dn       in   1    phase detector: feedback late
M        out  MW   applied ratio to divider
M_counter out MW   divider phase count
wrap     out  1    one-cycle pulse when M_counter returns to 0
dl_code  out  DCW  delay-line control code
locked   out  1    loop locked
settling out  1    high in SETTLE state

Behaviour:
- One clock: clk_ext. Reset is asynchronous and active-low: rst_n.
- Reset values:
  - M=M_RST, M_counter=0, wrap=0.
  - dl_code=2^(DCW-1), i.e. 32 at the default DCW=6.
  - locked=0, state=SETTLE, settle_cnt=0, lock_cnt=0, m_req_rdy=0 during reset, 1 on the first cycle after release.
- Counter:
  - M_counter counts 0..M-1, then wraps to 0. wrap_evt = (M_counter==M-1).
  - The wrap output is registered: it is high in the cycle M_counter==0 follows a wrap_evt.
  - M=1 gives a constant count of 0 and a wrap_evt every cycle.
- Ratio clamp: requested value 0 is clamped to 1 at acceptance.
- Handshake:
  - m_req_rdy = !pend. Accept on m_req_vld & m_req_rdy: m_pend<=clamped m_req, pend<=1.
  - At the next wrap_evt with pend=1:
    - If m_pend!=M: M<=m_pend, M_counter<=0, locked<=0, lock_cnt<=0, settle_cnt<=0, state<=SETTLE.
    - If m_pend==M: no state change and lock is retained.
    - In both cases pend<=0.
  - Acceptance and application in the same cycle do not occur. A request accepted on a wrap_evt cycle applies at the following wrap.
- FSM states are SETTLE and TRACK.
  - SETTLE:
    - dl_code frozen.
    - settle_cnt increments per wrap_evt. On reaching SETTLE_WRAPS-1 at a wrap_evt, go to TRACK.
    - A ratio change in SETTLE restarts settle_cnt.
  - TRACK, evaluated on wrap_evt only:
    - up&!dn: dl_code+1, saturating at 2^DCW-1.
    - dn&!up: dl_code-1, saturating at 0.
    - otherwise: hold.
    - A "step" is an actual code change. A saturated request counts as no step.
    - No step: lock_cnt increments, saturating. locked<=1 when lock_cnt reaches LOCK_WRAPS-1 on a no-step wrap.
    - Step: lock_cnt<=0.
    - Two consecutive steps in the same direction while locked: locked<=0.
- Reset mid-operation discards any pending request and restores all reset values immediately.
- All widths are unsigned. M-1 is computed in MW bits, and M>=1 is guaranteed by the clamp.

Decomposition:
- Package fmdll_pkg holds:
  - the state enum (ST_SETTLE, ST_TRACK)
  - default MW/DCW constants
  - the dl_code midpoint function
- Sub-module fmdll_wrap_cnt:
  - inputs: clk_ext, rst_n, M, load_zero
  - outputs: M_counter, wrap_evt, registered wrap
- Top contains the handshake, FSM, dl_code and lock logic.

Test Plan:
1. Reset release with M_RST=1, up=1, dn=0 held → 8 cycles of settling=1, then dl_code 32→33→34… one per cycle, stopping at 63; locked never asserts while stepping.
2. Tracking with up=dn=0 at M=3 → wrap every 3 cycles; locked rises at the 4th tracking wrap (12 cycles after SETTLE exit); dl_code is unchanged.
3. While locked at M=3, request m_req=2 mid-period → rdy drops the next cycle; M changes exactly at the wrap (counter 2→0); locked falls; settling=1 for 8 wraps (16 cycles); dl_code is retained.
4. Request m_req=3 while M=3 and locked → accepted, pend clears at next wrap, locked stays 1, no SETTLE entry.
5. Request m_req=0 → M becomes 1 at the next wrap; the counter holds 0 and wrap pulses every cycle.
6. Assert rst_n low mid-SETTLE with a pending request → all outputs return to reset values asynchronously; the pending request is lost; M=M_RST after release.
